// File: rtl/mfp_uart_rx_controller_pkg.sv
// Shared constants and state encoding for the UART receive controller.
package mfp_uart_rx_controller_pkg;

  localparam int MFP_UART_RX_FIFO_DEPTH = 16;
  localparam int MFP_UART_RX_TIMEOUT    = 1736;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_EXPIRED = 2'd2
  } rx_tmo_state_t;

endpackage

// File: rtl/mfp_uart_rx_fifo.sv
// Show-ahead byte FIFO: storage, read/write pointers and occupancy.
module mfp_uart_rx_fifo #(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_wr_data,
  output logic [7:0]    o_rd_data,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_rd_data = o_empty ? 8'h00 : r_mem[r_rd_ptr];

endmodule

// File: rtl/mfp_uart_rx_controller.sv
// UART receive controller: byte FIFO with overrun tracking, idle timeout and
// a registered interrupt on fill level, timeout or overrun.
module mfp_uart_rx_controller
  import mfp_uart_rx_controller_pkg::*;
#(
  parameter  int DEPTH          = MFP_UART_RX_FIFO_DEPTH,
  parameter  int TIMEOUT_CYCLES = MFP_UART_RX_TIMEOUT,
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    byte_data,
  input  logic          byte_ready,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  input  logic [CW-1:0] threshold,
  input  logic          irq_enable,
  input  logic          clear_overrun,
  output logic          overrun,
  output logic          timeout,
  output logic          irq
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_goes_empty;
  logic          w_level;
  logic          w_irq_next;

  rx_tmo_state_t r_state;
  logic [TW-1:0] r_idle;
  logic          r_timeout;
  logic          r_overrun;
  logic          r_irq;

  // A full FIFO still accepts a byte when the bus pops in the same cycle.
  assign w_push       = byte_ready & (~full | rd_en);
  assign w_pop        = rd_en & ~empty;
  assign w_drop       = byte_ready & full & ~rd_en;
  assign w_goes_empty = w_pop & ~w_push & (count == CW'(1));
  assign w_level      = (threshold != '0) & (count >= threshold);
  assign w_irq_next   = irq_enable & (w_level | r_timeout | r_overrun);

  mfp_uart_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wr_data(byte_data),
    .o_rd_data(rd_data),
    .o_count  (count),
    .o_empty  (empty),
    .o_full   (full)
  );

  // Idle-line timeout: any FIFO activity restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          r_idle    <= '0;
          r_timeout <= 1'b0;
          if (w_push) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_goes_empty) begin
            r_state <= ST_EMPTY;
            r_idle  <= '0;
          end else if (w_push | w_pop) begin
            r_idle <= '0;
          end else if (r_idle == TMO_LAST) begin
            r_state   <= ST_EXPIRED;
            r_timeout <= 1'b1;
          end else begin
            r_idle <= r_idle + TW'(1);
          end
        end
        ST_EXPIRED: begin
          if (w_goes_empty) begin
            r_state   <= ST_EMPTY;
            r_idle    <= '0;
            r_timeout <= 1'b0;
          end else if (w_push | w_pop) begin
            r_state   <= ST_WAIT;
            r_idle    <= '0;
            r_timeout <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_EMPTY;
          r_idle    <= '0;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overrun <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_drop)             r_overrun <= 1'b1;
      else if (clear_overrun) r_overrun <= 1'b0;
      r_irq <= w_irq_next;
    end
  end

  assign overrun = r_overrun;
  assign timeout = r_timeout;
  assign irq     = r_irq;

endmodule

// File: tb/tb_mfp_uart_rx_controller.sv
// Bench for mfp_uart_rx_controller: queue-based model checked every cycle plus directed literal checks.
module tb_mfp_uart_rx_controller;

  localparam int DEPTH = 16;
  localparam int TMO   = 1736;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready = 1'b0;
  logic          rd_en = 1'b0;
  logic [CW-1:0] threshold = '0;
  logic          irq_enable = 1'b1;
  logic          clear_overrun = 1'b0;
  logic [7:0]    rd_data;
  logic [CW-1:0] count;
  logic          empty, full, overrun, timeout, irq;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [7:0] q[$];
  int         m_idle = 0;
  bit         m_ovr = 1'b0;
  bit         m_irq = 1'b0;

  mfp_uart_rx_controller #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .byte_data(byte_data), .byte_ready(byte_ready),
    .rd_en(rd_en), .rd_data(rd_data), .count(count), .empty(empty), .full(full),
    .threshold(threshold), .irq_enable(irq_enable), .clear_overrun(clear_overrun),
    .overrun(overrun), .timeout(timeout), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_timeout();
    return (q.size() != 0) && (m_idle >= TMO);
  endfunction

  // Behavioural model: a byte queue, an idle-cycle count and two flags.
  always @(posedge clock) begin : model
    bit m_full, m_empty, push, pop, drop, irq_nx;
    if (reset) begin
      q.delete();
      m_idle = 0;
      m_ovr  = 1'b0;
      m_irq  = 1'b0;
    end else begin
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      irq_nx  = irq_enable && (((threshold != 0) && (q.size() >= int'(threshold))) ||
                               m_timeout() || m_ovr);
      push = byte_ready && (!m_full || rd_en);
      pop  = rd_en && !m_empty;
      drop = byte_ready && m_full && !rd_en;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(byte_data);
      if (drop) m_ovr = 1'b1;
      else if (clear_overrun) m_ovr = 1'b0;
      if (push || pop) m_idle = 0;
      else if (m_idle < TMO) m_idle = m_idle + 1;
      m_irq = irq_nx;
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      chk("m_rd_data", rd_data, (q.size() != 0) ? q[0] : 8'h00);
      chk("m_count",   count, q.size());
      chk("m_empty",   empty, q.size() == 0);
      chk("m_full",    full, q.size() == DEPTH);
      chk("m_overrun", overrun, m_ovr);
      chk("m_timeout", timeout, m_timeout());
      chk("m_irq",     irq, m_irq);
    end
  end

  task automatic drive(input bit rst, input bit br, input logic [7:0] d,
                       input bit rd, input bit clr);
    reset = rst; byte_ready = br; byte_data = d; rd_en = rd; clear_overrun = clr;
    @(posedge clock);
    #1;
    reset = 1'b0; byte_ready = 1'b0; rd_en = 1'b0; clear_overrun = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_rd_data"}, rd_data, 8'h00);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_irq"}, irq, 0);
  endtask

  initial begin
    drive(1, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0);
    mon_en = 1'b1;
    chk_reset_vals("rst");

    // Three bytes, drained in order.
    drive(0, 1, 8'h41, 0, 0);
    drive(0, 1, 8'h42, 0, 0);
    drive(0, 1, 8'h43, 0, 0);
    chk("t1_count", count, 3);
    chk("t1_rd0", rd_data, 8'h41);
    drive(0, 0, 8'h00, 1, 0);
    chk("t1_rd1", rd_data, 8'h42);
    drive(0, 0, 8'h00, 1, 0);
    chk("t1_rd2", rd_data, 8'h43);
    drive(0, 0, 8'h00, 1, 0);
    chk("t1_empty", empty, 1);
    drive(0, 0, 8'h00, 1, 0);
    chk("t1_pop_empty_cnt", count, 0);

    // Level interrupt at threshold 4.
    threshold = CW'(4);
    for (int i = 0; i < 4; i++) drive(0, 1, 8'h50 + 8'(i), 0, 0);
    chk("t2_irq_lat1", irq, 0);
    idle_n(1);
    chk("t2_irq_rise", irq, 1);
    drive(0, 0, 8'h00, 1, 0);
    chk("t2_cnt3", count, 3);
    chk("t2_irq_hold", irq, 1);
    idle_n(1);
    chk("t2_irq_fall", irq, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 1, 0);
    threshold = '0;

    // Overflow by one byte.
    for (int i = 1; i <= 17; i++) begin
      drive(0, 1, 8'(i), 0, 0);
      if (i == 16) begin
        chk("t3_full", full, 1);
        chk("t3_cnt16", count, 16);
        chk("t3_ovr_pre", overrun, 0);
      end
    end
    chk("t3_ovr", overrun, 1);
    chk("t3_head", rd_data, 8'h01);
    idle_n(1);
    chk("t3_irq", irq, 1);
    drive(0, 1, 8'hEE, 0, 1);
    chk("t3_set_wins", overrun, 1);
    drive(0, 0, 8'h00, 0, 1);
    chk("t3_clear", overrun, 0);
    idle_n(1);
    chk("t3_irq_fall", irq, 0);

    // Push and pop together while full.
    drive(0, 1, 8'hAA, 1, 0);
    chk("t4_cnt", count, 16);
    chk("t4_ovr", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      chk("t4_order", rd_data, (i < 15) ? 8'(i + 2) : 8'hAA);
      drive(0, 0, 8'h00, 1, 0);
    end
    chk("t4_empty", empty, 1);

    // Idle timeout after a single byte.
    drive(0, 1, 8'h5A, 0, 0);
    idle_n(TMO - 1);
    chk("t5_tmo_early", timeout, 0);
    idle_n(1);
    chk("t5_tmo", timeout, 1);
    chk("t5_irq_lat", irq, 0);
    idle_n(1);
    chk("t5_irq", irq, 1);
    drive(0, 0, 8'h00, 1, 0);
    chk("t5_tmo_clr", timeout, 0);
    chk("t5_empty", empty, 1);
    idle_n(1);
    chk("t5_irq_fall", irq, 0);

    // Reset in the middle of a burst.
    threshold = CW'(1);
    drive(0, 1, 8'h01, 0, 0);
    drive(0, 1, 8'h02, 0, 0);
    chk("t6_irq_pre", irq, 1);
    drive(1, 1, 8'h03, 0, 0);
    chk_reset_vals("t6");
    threshold = '0;
    drive(0, 1, 8'h04, 0, 0);
    drive(0, 1, 8'h05, 0, 0);
    chk("t6_cnt", count, 2);
    chk("t6_head", rd_data, 8'h04);
    drive(0, 0, 8'h00, 1, 0);
    chk("t6_next", rd_data, 8'h05);
    drive(0, 0, 8'h00, 1, 0);

    // Overrun with interrupts masked.
    irq_enable = 1'b0;
    for (int i = 0; i < 17; i++) drive(0, 1, 8'h80 + 8'(i), 0, 0);
    idle_n(2);
    chk("t7_ovr", overrun, 1);
    chk("t7_irq_masked", irq, 0);
    idle_n(2);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
